// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the RV32M multiply/divide unit
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam int ITERATIONS = 32;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of the shift-add multiply or the
//                restoring divide. For multiply, acc = {partial_hi, multiplier}
//                and operand = multiplicand. For divide, acc = {remainder,
//                dividend/quotient} and operand = divisor.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     operand,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    // Single step: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
    always_comb begin
        w_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        w_shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        w_diff    = w_shifted - {1'b0, operand};
        acc_next  = {w_sum, acc[XLEN-1:1]};
        if (is_div) begin
            // Remainder is always below the divisor, so bit XLEN of the
            // difference is set exactly when the trial subtraction borrows.
            if (!w_diff[XLEN]) begin
                acc_next = {w_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {w_shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : RV32M sequencer beside the EX-stage ALU. Runs a 32-cycle
//                shift-add multiply or restoring divide, stalls the pipeline
//                meanwhile, and presents a registered result for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [4:0]      C_LAST    = 5'(ITERATIONS - 1);

    muldiv_state_t      r_state;
    muldiv_state_t      w_state_next;
    logic [4:0]         r_count;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opd;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2:0]         r_f3;
    logic [XLEN-1:0]    r_result;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_abs;
    logic [XLEN-1:0]    w_b_abs;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_fast;
    logic [XLEN-1:0]    w_fast_result;
    logic               w_last;
    logic [2*XLEN-1:0]  w_acc_next;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_final;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (r_state == S_DIV),
        .acc      (r_acc),
        .operand  (r_opd),
        .acc_next (w_acc_next)
    );

    // Operand conditioning: signedness per funct3, magnitudes, and divide special cases
    always_comb begin
        w_accept   = start & ~flush;
        w_a_neg    = a[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                                  (funct3 == F3_DIV)  | (funct3 == F3_REM));
        w_b_neg    = b[XLEN-1] & ((funct3 == F3_MULH) | (funct3 == F3_DIV) |
                                  (funct3 == F3_REM));
        w_a_abs    = w_a_neg ? (~a + 1'b1) : a;
        w_b_abs    = w_b_neg ? (~b + 1'b1) : b;
        w_div_zero = (b == '0);
        w_div_ovf  = ~funct3[0] & (a == C_MIN_NEG) & (b == '1);
        w_fast     = funct3[2] & (w_div_zero | w_div_ovf);
        if (w_div_zero) begin
            w_fast_result = funct3[1] ? a : '1;
        end else begin
            w_fast_result = funct3[1] ? '0 : C_MIN_NEG;
        end
    end

    // Final sign fix-up and result selection on the last iteration
    always_comb begin
        w_last  = (r_count == C_LAST);
        w_prod  = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
        w_quo   = r_neg_q ? (~w_acc_next[XLEN-1:0] + 1'b1) : w_acc_next[XLEN-1:0];
        w_rem   = r_neg_r ? (~w_acc_next[2*XLEN-1:XLEN] + 1'b1) : w_acc_next[2*XLEN-1:XLEN];
        if (r_state == S_DIV) begin
            w_final = r_f3[1] ? w_rem : w_quo;
        end else begin
            w_final = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held start cannot retrigger
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!funct3[2])  w_state_next = S_MUL;
                    else if (w_fast) w_state_next = S_DONE;
                    else             w_state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (flush)       w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate, capture the result on the last step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_f3     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count <= '0;
                        r_f3    <= funct3;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (funct3[2]) begin
                            r_acc <= {{XLEN{1'b0}}, w_a_abs};
                            r_opd <= w_b_abs;
                            if (w_fast) r_result <= w_fast_result;
                        end else begin
                            r_acc <= {{XLEN{1'b0}}, w_b_abs};
                            r_opd <= w_a_abs;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        r_count <= '0;
                    end else begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + 5'd1;
                        if (w_last) r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall        = start & ~flush & (r_state != S_DONE);
    assign busy         = (r_state == S_MUL) | (r_state == S_DIV);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Directed self-checking bench for ex_muldiv_unit with a result
//                scoreboard and an independent arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .a            (a),
        .b            (b),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp;
        logic        [63:0] ux, uy, up;
        logic signed [31:0] s32x, s32y, sr;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        s32x = x;
        s32y = y;
        case (f)
            3'b000: begin up = ux * uy; return up[31:0]; end
            3'b001: begin sp = sx * sy; return sp[63:32]; end
            3'b010: begin sp = sx * $signed(uy); return sp[63:32]; end
            3'b011: begin up = ux * uy; return up[63:32]; end
            3'b100: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                sr = s32x / s32y; return sr;
            end
            3'b101: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'b110: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                sr = s32x % s32y; return sr;
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 32'd0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issue one op in the current cycle (cycle 0) and follow it to DONE and back to IDLE
    task automatic do_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_r, input int lat);
        logic [31:0] e;
        sb_q.push_back(exp_r);
        funct3 = f; a = av; b = bv; flush = 1'b0; start = 1'b1;
        #1;
        for (int c = 0; c < lat; c++) begin
            chk("stall_active", {31'd0, stall}, 32'd1);
            chk("valid_early", {31'd0, result_valid}, 32'd0);
            chk("busy_run", {31'd0, busy}, (c == 0) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
        end
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("valid_done", {31'd0, result_valid}, 32'd1);
        e = sb_q.pop_front();
        chk("result", result, e);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("no_retrigger", {31'd0, busy}, 32'd0);
        chk("valid_after", {31'd0, result_valid}, 32'd0);
    endtask

    task automatic do_model_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
        do_op(f, av, bv, model(f, av, bv), latency(f, av, bv));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Multiply variants
        do_op(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
        // Divide variants
        do_op(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        do_op(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        // Fast-path special cases
        do_op(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        do_op(3'b111, 32'd5,          32'd0,         32'd5,         1);
        do_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        do_op(3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);

        // Mixed operands checked against the reference model
        do_model_op(3'b001, 32'h8000_0000, 32'h8000_0000);
        do_model_op(3'b010, 32'h8000_0001, 32'hFFFF_FFFF);
        do_model_op(3'b101, 32'hDEAD_BEEF, 32'd17);
        do_model_op(3'b111, 32'hDEAD_BEEF, 32'h0001_0000);
        do_model_op(3'b110, 32'd100,       32'hFFFF_FFF9);
        for (int i = 0; i < 6; i++) begin
            do_model_op(3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        // Flush mid-divide: stall drops that cycle, no result, unit idle next cycle
        funct3 = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("flush_stall_pre", {31'd0, stall}, 32'd1);
            chk("flush_valid_pre", {31'd0, result_valid}, 32'd0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {31'd0, busy}, 32'd0);
        chk("flush_no_valid", {31'd0, result_valid}, 32'd0);
        do_op(3'b000, 32'd12345, 32'd678, 32'd8369910, 33);

        // Asynchronous reset in the middle of a divide
        funct3 = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_valid", {31'd0, result_valid}, 32'd0);
        chk("async_result", result, 32'd0);
        chk("async_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("reset_hold_busy", {31'd0, busy}, 32'd0);
        #2 reset = 1'b0;
        do_op(3'b101, 32'd1000, 32'd3, 32'd333, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
